// File: rtl/mem_stage.sv
// MEM pipeline stage: runs the LDW/STW bus transaction and loads the MEM/WB register.
// Define MEM_ALIGN_CHECK_EN to flag misaligned word accesses with MISS_ALIGN.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  output logic        busy,
  input  logic [29:0] ex_pc,
  input  logic        ex_en_,
  input  logic        ex_br_flag,
  input  logic [1:0]  ex_mem_op,
  input  logic [31:0] ex_mem_wr_data,
  input  logic [1:0]  ex_ctrl_op,
  input  logic [4:0]  ex_dst_addr,
  input  logic        ex_gpr_we_,
  input  logic [2:0]  ex_exp_code,
  input  logic [31:0] ex_out,
  output logic        bus_req_,
  input  logic        bus_grnt_,
  output logic        bus_as_,
  output logic [29:0] bus_addr,
  output logic        bus_rw,
  output logic [31:0] bus_wr_data,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rdy_,
  output logic [29:0] mem_pc,
  output logic        mem_en_,
  output logic        mem_br_flag,
  output logic [1:0]  mem_ctrl_op,
  output logic [4:0]  mem_dst_addr,
  output logic        mem_gpr_we_,
  output logic [2:0]  mem_exp_code,
  output logic [31:0] mem_out
);

  localparam logic [1:0] MemLdw       = 2'd1;
  localparam logic [1:0] MemStw       = 2'd2;
  localparam logic [2:0] ExpNo        = 3'd0;
  localparam logic [2:0] ExpMissAlign = 3'd4;

  typedef enum logic [1:0] {StIdle, StReq, StAccess, StStall} state_e;

  state_e      state_q;
  logic [31:0] rd_buf_q;
  logic        is_mem_op;
  logic        miss_align;
  logic        access;

  assign is_mem_op = (ex_mem_op == MemLdw) || (ex_mem_op == MemStw);

`ifdef MEM_ALIGN_CHECK_EN
  assign miss_align = is_mem_op && (ex_out[1:0] != 2'b00);
`else
  assign miss_align = 1'b0;
`endif

  assign access = !ex_en_ && is_mem_op && !miss_align && (ex_exp_code == ExpNo) && !flush;

  assign busy = ((state_q == StIdle) && access) || (state_q == StReq) ||
                ((state_q == StAccess) && bus_rdy_);

  // Once started, a bus cycle always runs to completion; flush only affects the MEM register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      bus_req_    <= 1'b1;
      bus_as_     <= 1'b1;
      bus_addr    <= '0;
      bus_rw      <= 1'b1;
      bus_wr_data <= '0;
      rd_buf_q    <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (access) begin
            bus_req_ <= 1'b0;
            state_q  <= StReq;
          end
        end
        StReq: begin
          if (!bus_grnt_) begin
            bus_as_     <= 1'b0;
            bus_addr    <= ex_out[31:2];
            bus_rw      <= (ex_mem_op == MemLdw);
            bus_wr_data <= (ex_mem_op == MemStw) ? ex_mem_wr_data : 32'h0;
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          bus_as_ <= 1'b1;
          if (!bus_rdy_) begin
            bus_req_ <= 1'b1;
            rd_buf_q <= bus_rd_data;
            state_q  <= stall ? StStall : StIdle;
          end
        end
        StStall: begin
          if (!stall) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [29:0] pc_d;
  logic        en_d;
  logic        br_flag_d;
  logic [1:0]  ctrl_op_d;
  logic [4:0]  dst_d;
  logic        gpr_we_d;
  logic [2:0]  exp_d;
  logic [31:0] out_d;

  always_comb begin
    pc_d      = ex_pc;
    en_d      = ex_en_;
    br_flag_d = ex_br_flag;
    ctrl_op_d = ex_ctrl_op;
    dst_d     = ex_dst_addr;
    gpr_we_d  = ex_gpr_we_;
    exp_d     = ex_exp_code;
    if ((ex_mem_op == MemLdw) && (state_q == StAccess)) begin
      out_d = bus_rd_data;
    end else if ((ex_mem_op == MemLdw) && (state_q == StStall)) begin
      out_d = rd_buf_q;
    end else begin
      out_d = ex_out;
    end

    if (flush) begin
      pc_d      = '0;
      en_d      = 1'b1;
      br_flag_d = 1'b0;
      ctrl_op_d = '0;
      dst_d     = '0;
      gpr_we_d  = 1'b1;
      exp_d     = ExpNo;
      out_d     = '0;
    end else if (miss_align && !ex_en_) begin
      ctrl_op_d = '0;
      dst_d     = '0;
      gpr_we_d  = 1'b1;
      exp_d     = ExpMissAlign;
      out_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_pc       <= '0;
      mem_en_      <= 1'b1;
      mem_br_flag  <= 1'b0;
      mem_ctrl_op  <= '0;
      mem_dst_addr <= '0;
      mem_gpr_we_  <= 1'b1;
      mem_exp_code <= ExpNo;
      mem_out      <= '0;
    end else if (!stall) begin
      mem_pc       <= pc_d;
      mem_en_      <= en_d;
      mem_br_flag  <= br_flag_d;
      mem_ctrl_op  <= ctrl_op_d;
      mem_dst_addr <= dst_d;
      mem_gpr_we_  <= gpr_we_d;
      mem_exp_code <= exp_d;
      mem_out      <= out_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: bus handshake timing, stall parking, flush and alignment.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, busy;
  logic [29:0] ex_pc;
  logic        ex_en_, ex_br_flag;
  logic [1:0]  ex_mem_op;
  logic [31:0] ex_mem_wr_data;
  logic [1:0]  ex_ctrl_op;
  logic [4:0]  ex_dst_addr;
  logic        ex_gpr_we_;
  logic [2:0]  ex_exp_code;
  logic [31:0] ex_out;
  logic        bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data, bus_rd_data;
  logic [29:0] mem_pc;
  logic        mem_en_, mem_br_flag, mem_gpr_we_;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_out;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
    .ex_pc(ex_pc), .ex_en_(ex_en_), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_addr(bus_addr),
    .bus_rw(bus_rw), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_rdy_(bus_rdy_), .mem_pc(mem_pc), .mem_en_(mem_en_), .mem_br_flag(mem_br_flag),
    .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
    .mem_exp_code(mem_exp_code), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    ex_pc = '0; ex_en_ = 1'b1; ex_br_flag = 1'b0; ex_mem_op = 2'd0; ex_mem_wr_data = '0;
    ex_ctrl_op = '0; ex_dst_addr = '0; ex_gpr_we_ = 1'b1; ex_exp_code = 3'd0; ex_out = '0;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd);
    ex_pc = 30'h123; ex_en_ = 1'b0; ex_br_flag = 1'b0; ex_mem_op = op; ex_mem_wr_data = wd;
    ex_ctrl_op = 2'd0; ex_dst_addr = 5'd7; ex_gpr_we_ = (op == 2'd2); ex_exp_code = 3'd0;
    ex_out = addr;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    bus_rd_data = '0; set_idle();
    tick(); tick();
    n_tests++; if ({bus_req_, bus_as_, bus_rw} !== 3'b111) begin n_fail++;
      $display("FAIL reset_bus_ctl: got %b want 111", {bus_req_, bus_as_, bus_rw}); end
    n_tests++; if (bus_addr !== 30'h0 || bus_wr_data !== 32'h0) begin n_fail++;
      $display("FAIL reset_bus_data: got %h/%h want 0/0", bus_addr, bus_wr_data); end
    n_tests++; if ({mem_en_, mem_gpr_we_, mem_exp_code} !== 5'b11000 || mem_out !== 32'h0)
      begin n_fail++; $display("FAIL reset_mem: got en/we/exp %b out %h want 11000 out 0",
        {mem_en_, mem_gpr_we_, mem_exp_code}, mem_out); end
    n_tests++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_alu();
    set_op(2'd0, 32'h1234, 32'h0);
    ex_gpr_we_ = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL alu_busy: got %b want 0", busy); end
    tick();
    n_tests++; if (mem_out !== 32'h1234 || mem_gpr_we_ !== 1'b0) begin n_fail++;
      $display("FAIL alu_result: got %h we %b want 00001234 we 0", mem_out, mem_gpr_we_); end
    n_tests++; if (bus_req_ !== 1'b1) begin n_fail++;
      $display("FAIL alu_no_req: got %b want 1", bus_req_); end
    set_idle();
  endtask

  task automatic test_ldw();
    int busy_cnt = 0;
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'hDEADBEEF;
    set_op(2'd1, 32'h100, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      if (k == 1) begin
        n_tests++; if (bus_req_ !== 1'b0) begin n_fail++;
          $display("FAIL ldw_req: got %b want 0", bus_req_); end
      end
      if (k == 2) begin
        n_tests++; if (bus_as_ !== 1'b0 || bus_addr !== 30'h40 || bus_rw !== 1'b1) begin
          n_fail++; $display("FAIL ldw_access: got as %b addr %h rw %b want 0 00000040 1",
            bus_as_, bus_addr, bus_rw); end
      end
      busy_cnt += int'(busy);
      tick();
    end
    set_idle();
    n_tests++; if (mem_out !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL ldw_data: got %h want deadbeef", mem_out); end
    n_tests++; if (busy_cnt != 2) begin n_fail++;
      $display("FAIL ldw_busy_cycles: got %0d want 2", busy_cnt); end
    n_tests++; if (bus_req_ !== 1'b1 || bus_as_ !== 1'b1) begin n_fail++;
      $display("FAIL ldw_release: got req %b as %b want 1 1", bus_req_, bus_as_); end
  endtask

  task automatic test_stw();
    int busy_cnt = 0;
    int as_cnt = 0;
    bus_grnt_ = 1'b0; bus_rd_data = 32'h0;
    set_op(2'd2, 32'h104, 32'hA5A5A5A5);
    for (int k = 0; k < 6; k++) begin
      bus_rdy_ = (k == 5) ? 1'b0 : 1'b1;
      #1;
      if (k == 2) begin
        n_tests++; if (bus_rw !== 1'b0 || bus_wr_data !== 32'hA5A5A5A5 || bus_addr !== 30'h41)
          begin n_fail++; $display("FAIL stw_access: got rw %b wd %h addr %h want 0 a5a5a5a5 41",
            bus_rw, bus_wr_data, bus_addr); end
      end
      busy_cnt += int'(busy);
      as_cnt += int'(!bus_as_);
      tick();
    end
    set_idle();
    bus_rdy_ = 1'b0;
    n_tests++; if (busy_cnt != 5) begin n_fail++;
      $display("FAIL stw_busy_cycles: got %0d want 5", busy_cnt); end
    n_tests++; if (as_cnt != 1) begin n_fail++;
      $display("FAIL stw_as_pulse: got %0d want 1", as_cnt); end
    n_tests++; if (bus_req_ !== 1'b1) begin n_fail++;
      $display("FAIL stw_release: got %b want 1", bus_req_); end
  endtask

  task automatic test_align();
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFEF00D;
    set_op(2'd1, 32'h102, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++;
      $display("FAIL align_busy: got %b want 0", busy); end
    tick();
    set_idle();
    n_tests++; if (mem_exp_code !== 3'd4 || mem_gpr_we_ !== 1'b1 || mem_out !== 32'h0) begin
      n_fail++; $display("FAIL align_exp: got exp %0d we %b out %h want 4 1 0",
        mem_exp_code, mem_gpr_we_, mem_out); end
    n_tests++; if (bus_req_ !== 1'b1) begin n_fail++;
      $display("FAIL align_no_req: got %b want 1", bus_req_); end
`else
    for (int k = 0; k < 3; k++) begin
      #1;
      if (k == 2) begin
        n_tests++; if (bus_addr !== 30'h40 || bus_as_ !== 1'b0) begin n_fail++;
          $display("FAIL align_addr: got addr %h as %b want 00000040 0", bus_addr, bus_as_); end
      end
      tick();
    end
    set_idle();
    n_tests++; if (mem_out !== 32'hCAFEF00D || mem_exp_code !== 3'd0) begin n_fail++;
      $display("FAIL align_data: got %h exp %0d want cafef00d 0", mem_out, mem_exp_code); end
`endif
  endtask

  task automatic test_stall();
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'h13579BDF;
    set_op(2'd1, 32'h200, 32'h0);
    for (int k = 0; k < 6; k++) begin
      stall = (k >= 2 && k <= 4);
      if (k == 3) begin bus_rd_data = 32'h0; bus_rdy_ = 1'b1; end
      #1;
      if (k == 3) begin
        n_tests++; if (busy !== 1'b0) begin n_fail++;
          $display("FAIL stall_busy: got %b want 0", busy); end
      end
      if (k == 5) begin
        n_tests++; if (mem_out !== 32'h200) begin n_fail++;
          $display("FAIL stall_hold: got %h want 00000200", mem_out); end
      end
      tick();
    end
    set_idle();
    stall = 1'b0; bus_rdy_ = 1'b0;
    n_tests++; if (mem_out !== 32'h13579BDF) begin n_fail++;
      $display("FAIL stall_data: got %h want 13579bdf", mem_out); end
  endtask

  task automatic test_flush();
    int as_cnt = 0;
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'h55AA55AA;
    set_op(2'd1, 32'h300, 32'h0);
    for (int k = 0; k < 5; k++) begin
      flush = (k >= 1);
      #1;
      if (k == 3) begin
        n_tests++; if (mem_en_ !== 1'b1 || mem_gpr_we_ !== 1'b1 || mem_out !== 32'h0) begin
          n_fail++; $display("FAIL flush_bubble: got en %b we %b out %h want 1 1 0",
            mem_en_, mem_gpr_we_, mem_out); end
      end
      as_cnt += int'(!bus_as_);
      tick();
    end
    flush = 1'b0;
    set_idle();
    n_tests++; if (as_cnt != 1) begin n_fail++;
      $display("FAIL flush_as_pulse: got %0d want 1", as_cnt); end
    n_tests++; if (bus_req_ !== 1'b1) begin n_fail++;
      $display("FAIL flush_release: got %b want 1", bus_req_); end
  endtask

  task automatic test_reset_mid();
    bus_grnt_ = 1'b0; bus_rdy_ = 1'b1;
    set_op(2'd1, 32'h400, 32'h0);
    tick(); tick();
    n_tests++; if (bus_as_ !== 1'b0) begin n_fail++;
      $display("FAIL rst_mid_access: got as %b want 0", bus_as_); end
    reset = 1'b1;
    tick();
    set_idle();
    #1;
    n_tests++; if (bus_as_ !== 1'b1 || bus_req_ !== 1'b1 || busy !== 1'b0 || mem_en_ !== 1'b1)
      begin n_fail++; $display("FAIL rst_mid_release: got as %b req %b busy %b en %b want 1 1 0 1",
        bus_as_, bus_req_, busy, mem_en_); end
    reset = 1'b0; bus_rdy_ = 1'b0;
    tick();
    n_tests++; if (bus_req_ !== 1'b1) begin n_fail++;
      $display("FAIL rst_mid_idle: got req %b want 1", bus_req_); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ldw();
    test_stw();
    test_align();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
